// File: rtl/card_pkg.sv
// Shared card, deck and FSM definitions for the video-poker card source.
// Card codes are {suit, rank}, with rank 1 = Ace through 13 = King.
package card_pkg;

  localparam int unsigned RANK_W    = 4;
  localparam int unsigned SUIT_W    = 2;
  localparam int unsigned CARD_W    = RANK_W + SUIT_W;
  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned HAND_SIZE = 5;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [SUIT_W-1:0] suit;
    logic [RANK_W-1:0] rank;
  } card_t;

  typedef logic [2:0] state_t;
  localparam state_t StIdle    = 3'd0;
  localparam state_t StShuf    = 3'd1;
  localparam state_t StShufAck = 3'd2;
  localparam state_t StDeal    = 3'd3;
  localparam state_t StRes     = 3'd4;

  // Card held at position idx of a freshly ordered deck.
  function automatic card_t init_card(input int unsigned idx);
    card_t c;
    c.suit = SUIT_W'(idx / 13);
    c.rank = RANK_W'((idx % 13) + 1);
    return c;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/deck_lfsr.sv
// 16-bit Galois LFSR with advance and load; a zero value is never held.
module deck_lfsr
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] value
);

  localparam logic [15:0] SafeSeed = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (load_val == 16'h0000) ? SafeSeed : load_val;
    end else if (advance) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SafeSeed;
    end else begin
      state_q <= state_d;
    end
  end

  assign value = state_q;

endmodule

// File: rtl/deck_dealer.sv
// 52-card deck holder: LFSR Fisher-Yates shuffle and 5-card dealing to the resolver.
// Optional DECK_ENTROPY_EN mixes a free-running cycle counter into the LFSR on shuffle entry.
module deck_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              deal,
  input  logic              shuffle,
  output logic              shuffled,
  output logic              resolve,
  input  logic              resolved,
  output logic [RANK_W-1:0] rank0,
  output logic [RANK_W-1:0] rank1,
  output logic [RANK_W-1:0] rank2,
  output logic [RANK_W-1:0] rank3,
  output logic [RANK_W-1:0] rank4,
  output logic [SUIT_W-1:0] suit0,
  output logic [SUIT_W-1:0] suit1,
  output logic [SUIT_W-1:0] suit2,
  output logic [SUIT_W-1:0] suit3,
  output logic [SUIT_W-1:0] suit4,
  output logic              busy
);

  state_t      state_q, state_d;
  card_t       deck_q [DECK_SIZE];
  card_t       deck_d [DECK_SIZE];
  card_t       hand_q [HAND_SIZE];
  card_t       hand_d [HAND_SIZE];
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  slot_q, slot_d;
  logic        shuf_pend_q, shuf_pend_d;
  logic        deal_pend_q, deal_pend_d;
  logic        ext_q, ext_d;
  logic        deal_after_q, deal_after_d;

  logic        shuf_go;
  logic        lfsr_adv;
  logic        lfsr_load;
  logic [15:0] lfsr_load_val;
  logic [15:0] lfsr_val;
  logic [5:0]  cand;

`ifdef DECK_ENTROPY_EN
  logic [15:0] cnt_q, cnt_d;
`else
  logic        unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_val[15:6];
`endif

  assign cand = lfsr_val[5:0];

  deck_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (lfsr_adv),
    .load    (lfsr_load),
    .load_val(lfsr_load_val),
    .value   (lfsr_val)
  );

  always_comb begin
    state_d       = state_q;
    deck_d        = deck_q;
    hand_d        = hand_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    slot_d        = slot_q;
    shuf_pend_d   = shuf_pend_q;
    deal_pend_d   = deal_pend_q;
    ext_d         = ext_q;
    deal_after_d  = deal_after_q;
    shuf_go       = 1'b0;
    lfsr_adv      = 1'b0;
    lfsr_load     = 1'b0;
    lfsr_load_val = 16'h0000;

    case (state_q)
      StIdle: begin
        if (shuf_pend_q) begin
          shuf_pend_d  = 1'b0;
          deal_pend_d  = deal_pend_q | deal;
          ext_d        = 1'b1;
          deal_after_d = 1'b0;
          shuf_go      = 1'b1;
        end else begin
          shuf_pend_d = shuffle;
          if (deal || deal_pend_q) begin
            deal_pend_d = 1'b0;
            // Too few cards left for a full hand: reshuffle silently first.
            if (ptr_q > 6'd47) begin
              ext_d        = 1'b0;
              deal_after_d = 1'b1;
              shuf_go      = 1'b1;
            end else begin
              state_d = StDeal;
              slot_d  = 3'd0;
            end
          end
        end
        if (shuf_go) begin
          state_d = StShuf;
          idx_d   = 6'(DECK_SIZE - 1);
        end
      end

      StShuf: begin
        deal_pend_d = deal_pend_q | deal;
        lfsr_adv    = 1'b1;
        if (cand <= idx_q) begin
          deck_d[idx_q] = deck_q[cand];
          deck_d[cand]  = deck_q[idx_q];
          idx_d         = idx_q - 6'd1;
          if (idx_q == 6'd1) begin
            ptr_d = 6'd0;
            if (ext_q || shuf_pend_q) begin
              shuf_pend_d = 1'b0;
              state_d     = StShufAck;
            end else begin
              state_d = StDeal;
              slot_d  = 3'd0;
            end
          end
        end
      end

      StShufAck: begin
        deal_pend_d = deal_pend_q | deal;
        if (!shuffle) begin
          state_d      = deal_after_q ? StDeal : StIdle;
          slot_d       = 3'd0;
          deal_after_d = 1'b0;
        end
      end

      StDeal: begin
        deal_pend_d = deal_pend_q | deal;
        shuf_pend_d = shuf_pend_q | shuffle;
        if (slot_q < 3'(HAND_SIZE)) begin
          hand_d[slot_q] = deck_q[ptr_q];
          ptr_d          = ptr_q + 6'd1;
          slot_d         = slot_q + 3'd1;
        end else begin
          state_d = StRes;
        end
      end

      StRes: begin
        deal_pend_d = deal_pend_q | deal;
        shuf_pend_d = shuf_pend_q | shuffle;
        if (resolved) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

`ifdef DECK_ENTROPY_EN
    cnt_d         = cnt_q + 16'd1;
    lfsr_load     = shuf_go;
    lfsr_load_val = lfsr_val ^ cnt_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      for (int unsigned i = 0; i < DECK_SIZE; i++) deck_q[i] <= init_card(i);
      for (int unsigned k = 0; k < HAND_SIZE; k++) hand_q[k] <= '0;
      ptr_q        <= 6'd0;
      idx_q        <= 6'd0;
      slot_q       <= 3'd0;
      shuf_pend_q  <= 1'b0;
      deal_pend_q  <= 1'b0;
      ext_q        <= 1'b0;
      deal_after_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      deck_q       <= deck_d;
      hand_q       <= hand_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      shuf_pend_q  <= shuf_pend_d;
      deal_pend_q  <= deal_pend_d;
      ext_q        <= ext_d;
      deal_after_q <= deal_after_d;
    end
  end

`ifdef DECK_ENTROPY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign busy     = (state_q != StIdle);
  assign resolve  = (state_q == StRes);
  assign shuffled = (state_q == StShufAck);
  assign rank0    = hand_q[0].rank;
  assign rank1    = hand_q[1].rank;
  assign rank2    = hand_q[2].rank;
  assign rank3    = hand_q[3].rank;
  assign rank4    = hand_q[4].rank;
  assign suit0    = hand_q[0].suit;
  assign suit1    = hand_q[1].suit;
  assign suit2    = hand_q[2].suit;
  assign suit3    = hand_q[3].suit;
  assign suit4    = hand_q[4].suit;

endmodule

// File: tb/tb_deck_dealer.sv
// Self-checking bench for deck_dealer: procedural reference model plus directed and random stimulus.
module tb_deck_dealer;

  logic       clk;
  logic       rst_n;
  logic       deal;
  logic       shuffle;
  logic       resolved;
  logic       shuffled;
  logic       resolve;
  logic       busy;
  logic [3:0] rank0, rank1, rank2, rank3, rank4;
  logic [1:0] suit0, suit1, suit2, suit3, suit4;

  int total = 0;
  int bad   = 0;

  deck_dealer #(
    .SEED(16'hACE1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .deal    (deal),
    .shuffle (shuffle),
    .shuffled(shuffled),
    .resolve (resolve),
    .resolved(resolved),
    .rank0   (rank0),
    .rank1   (rank1),
    .rank2   (rank2),
    .rank3   (rank3),
    .rank4   (rank4),
    .suit0   (suit0),
    .suit1   (suit1),
    .suit2   (suit2),
    .suit3   (suit3),
    .suit4   (suit4),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic bit [15:0] lfsr_step(input bit [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  int      m_deck [52];
  int      m_ptr;
  bit [15:0] m_lfsr;
  bit      m_shuf_pend, m_deal_pend;
  bit      dead;
  bit      s_deal, s_shuf, s_res;
  bit      exp_busy, exp_resolve, exp_shuffled;
  bit [3:0] exp_rank [5];
  bit [1:0] exp_suit [5];

  task automatic model_reset();
    for (int i = 0; i < 52; i++) m_deck[i] = (i / 13) * 16 + (i % 13) + 1;
    m_ptr = 0;
    m_lfsr = 16'hACE1;
    m_shuf_pend = 0;
    m_deal_pend = 0;
    exp_busy = 0;
    exp_resolve = 0;
    exp_shuffled = 0;
    for (int k = 0; k < 5; k++) begin
      exp_rank[k] = 0;
      exp_suit[k] = 0;
    end
  endtask

  // One clock edge; inputs captured as seen by the DUT at that edge.
  task automatic tick();
    @(posedge clk or negedge rst_n);
    if (!rst_n) dead = 1;
    else begin
      s_deal = deal;
      s_shuf = shuffle;
      s_res  = resolved;
    end
  endtask

  task automatic note_busy_requests(input bit track_shuffle);
    if (s_deal) m_deal_pend = 1;
    if (track_shuffle && s_shuf) m_shuf_pend = 1;
  endtask

  task automatic m_deal_hand();
    int code;
    exp_busy = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (dead) return;
      note_busy_requests(1);
      code = m_deck[m_ptr];
      exp_rank[k] = 4'(code % 16);
      exp_suit[k] = 2'(code / 16);
      m_ptr++;
    end
    tick();
    if (dead) return;
    note_busy_requests(1);
    exp_resolve = 1;
    do begin
      tick();
      if (dead) return;
      note_busy_requests(1);
    end while (!s_res);
    exp_resolve = 0;
    exp_busy = 0;
  endtask

  task automatic m_shuffle(input bit ext, input bit after);
    int i, c, t;
    exp_busy = 1;
    i = 51;
    while (i > 0) begin
      tick();
      if (dead) return;
      note_busy_requests(0);
      c = int'(m_lfsr % 64);
      if (c <= i) begin
        t = m_deck[i];
        m_deck[i] = m_deck[c];
        m_deck[c] = t;
        i--;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    m_ptr = 0;
    if (ext || m_shuf_pend) begin
      m_shuf_pend = 0;
      exp_shuffled = 1;
      do begin
        tick();
        if (dead) return;
        note_busy_requests(0);
      end while (s_shuf);
      exp_shuffled = 0;
    end
    if (after) m_deal_hand();
    else exp_busy = 0;
  endtask

  task automatic m_idle_step();
    tick();
    if (dead) return;
    if (m_shuf_pend) begin
      m_shuf_pend = 0;
      if (s_deal) m_deal_pend = 1;
      m_shuffle(1, 0);
    end else begin
      if (s_shuf) m_shuf_pend = 1;
      if (s_deal || m_deal_pend) begin
        m_deal_pend = 0;
        if (m_ptr > 47) m_shuffle(0, 1);
        else m_deal_hand();
      end
    end
  endtask

  initial begin : model_thread
    forever begin
      model_reset();
      wait (rst_n === 1'b1);
      dead = 0;
      while (!dead) m_idle_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  function automatic logic [29:0] exp_hand();
    return {exp_rank[0], exp_rank[1], exp_rank[2], exp_rank[3], exp_rank[4],
            exp_suit[0], exp_suit[1], exp_suit[2], exp_suit[3], exp_suit[4]};
  endfunction

  logic [29:0] dut_hand;
  assign dut_hand = {rank0, rank1, rank2, rank3, rank4, suit0, suit1, suit2, suit3, suit4};

  bit saw_shuffled;
  int resolve_rises;
  logic resolve_prev;

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("resolve", {31'd0, resolve}, {31'd0, exp_resolve});
    chk("shuffled", {31'd0, shuffled}, {31'd0, exp_shuffled});
    chk("hand", {2'd0, dut_hand}, {2'd0, exp_hand()});
    if (shuffled) saw_shuffled = 1;
    if (resolve && !resolve_prev) resolve_rises++;
    resolve_prev = resolve;
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_deal();
    @(negedge clk);
    deal = 1;
    @(negedge clk);
    deal = 0;
  endtask

  task automatic wait_resolve(input int budget);
    int n = 0;
    while (resolve !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (resolve !== 1'b1) timeout("wait_resolve");
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (busy !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b1) timeout("wait_busy");
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) timeout("wait_idle");
  endtask

  task automatic wait_shuffled(input int budget);
    int n = 0;
    while (shuffled !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (shuffled !== 1'b1) timeout("wait_shuffled");
  endtask

  task automatic finish_hand();
    wait_resolve(100);
    resolved = 1;
    @(negedge clk);
    resolved = 0;
  endtask

  logic [5:0] codes [50];

  initial begin : stim
    int dups, mism, hands;
    rst_n = 0;
    deal = 0;
    shuffle = 0;
    resolved = 0;
    resolve_prev = 0;
    resolve_rises = 0;
    saw_shuffled = 0;
    #1;
    chk("pin_lfsr_step", {16'd0, lfsr_step(16'hACE1)}, 32'h0000E270);
    chk("pin_deck_top", m_deck[51], 32'h3D);
    chk("pin_deck_14", m_deck[14], 32'h12);

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_hand", {2'd0, dut_hand}, 0);
    rst_n = 1;

    // First deal: resolve exactly six edges after acceptance.
    pulse_deal();
    chk("deal_busy", {31'd0, busy}, 1);
    repeat (5) @(negedge clk);
    chk("resolve_t5", {31'd0, resolve}, 0);
    @(negedge clk);
    chk("resolve_t6", {31'd0, resolve}, 1);
    chk("hand1_ranks", {12'd0, rank0, rank1, rank2, rank3, rank4}, 32'h12345);
    chk("hand1_suits", {22'd0, suit0, suit1, suit2, suit3, suit4}, 0);
    repeat (10) @(negedge clk);
    chk("resolve_held", {31'd0, resolve}, 1);
    finish_hand();
    chk("resolve_drop", {31'd0, resolve}, 0);

    pulse_deal();
    wait_resolve(20);
    chk("hand2_ranks", {12'd0, rank0, rank1, rank2, rank3, rank4}, 32'h6789A);
    chk("hand2_suits", {22'd0, suit0, suit1, suit2, suit3, suit4}, 0);
    finish_hand();

    pulse_deal();
    wait_resolve(20);
    chk("hand3_ranks", {12'd0, rank0, rank1, rank2, rank3, rank4}, 32'hBCD12);
    chk("hand3_suits", {22'd0, suit0, suit1, suit2, suit3, suit4}, 32'h005);

    // Shuffle request while resolving.
    shuffle = 1;
    repeat (2) @(negedge clk);
    finish_hand();
    wait_shuffled(3000);
    repeat (3) begin
      @(negedge clk);
      chk("shuffled_hold", {31'd0, shuffled}, 1);
    end
    shuffle = 0;
    @(negedge clk);
    chk("shuffled_fall", {31'd0, shuffled}, 0);

    for (int h = 0; h < 10; h++) begin
      pulse_deal();
      wait_resolve(20);
      codes[h*5+0] = {suit0, rank0};
      codes[h*5+1] = {suit1, rank1};
      codes[h*5+2] = {suit2, rank2};
      codes[h*5+3] = {suit3, rank3};
      codes[h*5+4] = {suit4, rank4};
      finish_hand();
    end
    dups = 0;
    mism = 0;
    for (int a = 0; a < 50; a++) begin
      if (int'(codes[a]) != m_deck[a]) mism++;
      for (int b = a + 1; b < 50; b++) if (codes[a] == codes[b]) dups++;
    end
    chk("deck_distinct", dups, 0);
    chk("deck_order", mism, 0);

    // Eleventh hand forces a silent reshuffle.
    saw_shuffled = 0;
    pulse_deal();
    wait_resolve(3000);
    chk("internal_no_ack", {31'd0, saw_shuffled}, 0);
    finish_hand();

    // Deals during an external shuffle: one held, the second dropped.
    @(negedge clk);
    shuffle = 1;
    wait_busy(10);
    repeat (3) @(negedge clk);
    pulse_deal();
    repeat (4) @(negedge clk);
    pulse_deal();
    wait_shuffled(3000);
    shuffle = 0;
    resolve_rises = 0;
    wait_resolve(50);
    finish_hand();
    repeat (20) @(negedge clk);
    hands = resolve_rises;
    chk("one_hand_only", hands, 1);

    // Random traffic, model checked every cycle.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      deal = ($urandom_range(0, 9) == 0);
      resolved = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) shuffle = ~shuffle;
    end
    @(negedge clk);
    deal = 0;
    shuffle = 0;
    resolved = 1;
    wait_idle(3000);
    repeat (5) @(negedge clk);
    wait_idle(3000);
    resolved = 0;

    // Reset in the middle of a shuffle.
    @(negedge clk);
    shuffle = 1;
    wait_busy(10);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_shuffled", {31'd0, shuffled}, 0);
    chk("rst_hand", {2'd0, dut_hand}, 0);
    shuffle = 0;
    @(negedge clk);
    rst_n = 1;
    pulse_deal();
    wait_resolve(20);
    chk("post_rst_ranks", {12'd0, rank0, rank1, rank2, rank3, rank4}, 32'h12345);
    chk("post_rst_suits", {22'd0, suit0, suit1, suit2, suit3, suit4}, 0);
    finish_hand();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
